k051962_tile_shifter: RTL and testbench
=======================================

K051962_TILE_SHIFTER -- requirements
Module: k051962_tile_shifter

Interface
REQ-001 SHALL have parameter ATTR_W, default 8: width of the colour attribute carried alongside each pixel.
REQ-002 SHALL have port CK, input, 1: single system clock; all state changes on its rising edge.
REQ-003 SHALL have port CL, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port PE, input, 1: pixel enable; one CK-cycle pulse per pixel; every non-reset state change requires PE=1.
REQ-005 SHALL have port LOAD, input, 1: load tile word; sampled only when PE=1.
REQ-006 SHALL have port D, input, 32: tile ROM word; plane3=D[31:24], plane2=D[23:16], plane1=D[15:8], plane0=D[7:0].
REQ-007 SHALL have port FLIPX, input, 1: horizontal flip; sampled with LOAD.
REQ-008 SHALL have port ATTR, input, ATTR_W: colour attribute; sampled with LOAD.
REQ-009 SHALL have port FINE, input, 3: fine horizontal scroll delay, 0-7 pixels.
REQ-010 SHALL have port PIX, output, 4: registered pixel colour index.
REQ-011 SHALL have port COL, output, ATTR_W: registered attribute paired with PIX.
REQ-012 SHALL have port TRANS, output, 1: high when PIX==0.
REQ-013 SHALL have port CNT, output, 3: pixel phase within the current tile.
REQ-014 SHALL have port LDERR, output, 1: sticky flag for a misaligned load.
REQ-015 SHALL have port UNDR, output, 1: sticky flag for a missing load.

Function
REQ-016 Shift stage: on PE&LOAD, SHALL load four 8-bit plane registers from D, bit-reversing each plane when FLIPX=1, and SHALL latch ATTR; CNT<=0.
REQ-017 Raw pixel SHALL be {plane3[7],plane2[7],plane1[7],plane0[7]}; pixel i, i=0 leftmost, is {D[31-i],D[23-i],D[15-i],D[7-i]} when FLIPX=0.
REQ-018 On PE without LOAD, SHALL shift each plane left by 1, fill with 0, and set CNT<=CNT+1 mod 8.
REQ-019 Delay line: 8 entries L0..L7 of {attr,raw}; on each PE, L0<={attr,raw} and Lk<=L(k-1); sampled before the shift-stage update.
REQ-020 Output: on each PE, {COL,PIX} SHALL take {attr,raw} when FINE=0, else L(FINE-1); FINE is sampled at that edge.
REQ-021 Latency: pixel 0 of a word loaded at PE edge n SHALL appear on PIX after PE edge n+1+FINE; later pixels follow at one per PE.
REQ-022 Between PE pulses, all registers and outputs SHALL hold.
REQ-023 TRANS SHALL be combinational from the registered PIX.
REQ-024 PE&LOAD with CNT!=7 SHALL still load and SHALL set LDERR=1.
REQ-025 PE without LOAD at CNT=7 SHALL wrap CNT to 0, SHALL shift in zeros (transparent pixels), and SHALL set UNDR=1.
REQ-026 LDERR and UNDR SHALL clear only on reset.
REQ-027 A FINE change mid-tile SHALL take effect at the next PE, which may repeat or skip pixels; no other side effect.

Reset
REQ-028 While CL=1, SHALL force: planes=0, attr=0, L0..L7=0, PIX=0, COL=0, CNT=7, LDERR=0, UNDR=0, so TRANS=1.
REQ-029 After CL falls, the first PE&LOAD SHALL count as aligned (CNT=7).
REQ-030 CL asserted mid-tile SHALL discard all in-flight pixels immediately, without waiting for CK.

Verification
REQ-031 Reset then PE every cycle, FINE=0, FLIPX=0, LOAD once with D=32'hFF000F0F, ATTR=8'h5A, then LOAD every 8th PE -> PIX=8,8,8,8,B,B,B,B from edge n+1; COL=5A; LDERR=0.
REQ-032 Same stimulus with FLIPX=1 -> PIX=B,B,B,B,8,8,8,8.
REQ-033 FINE=3, D=32'h80000000 -> PIX=8 on exactly one pixel, after PE edge n+4; TRANS=1 on all other pixels.
REQ-034 PE high on only every 3rd CK -> outputs change only on PE edges; sequence identical to REQ-031.
REQ-035 LOAD at CNT=3 -> LDERR=1, new word starts; omit a LOAD at CNT=7 -> UNDR=1, PIX=0 with TRANS=1 for 8 pixels.
REQ-036 CL pulse mid-tile, asynchronous to CK -> PIX=0, COL=0, CNT=7, flags 0 before the next CK edge.

Source files
------------

// File: rtl/k051962_tile_shifter.sv
// Four-plane tile pixel shifter with an 8-deep fine-scroll delay line.
// Emits one {attribute, colour index} per pixel-enable pulse.
module k051962_tile_shifter #(
   parameter int ATTR_W = 8
) (
   input  logic              CK,
   input  logic              CL,
   input  logic              PE,
   input  logic              LOAD,
   input  logic [31:0]       D,
   input  logic              FLIPX,
   input  logic [ATTR_W-1:0] ATTR,
   input  logic [2:0]        FINE,
   output logic [3:0]        PIX,
   output logic [ATTR_W-1:0] COL,
   output logic              TRANS,
   output logic [2:0]        CNT,
   output logic              LDERR,
   output logic              UNDR
);

   localparam int EW = ATTR_W + 4;

   logic [31:0]       pl_q, pl_d;
   logic [ATTR_W-1:0] attr_q, attr_d;
   logic [2:0]        cnt_q, cnt_d;
   logic              lderr_q, lderr_d;
   logic              undr_q, undr_d;
   logic [EW-1:0]     out_q, out_d;
   logic [EW-1:0]     dl_q [8];
   logic [EW-1:0]     dl_d [8];
   logic [3:0]        raw;
   logic [EW-1:0]     entry;

   function automatic logic [7:0] rev8(input logic [7:0] b);
      for (int i = 0; i < 8; i++) rev8[i] = b[7-i];
   endfunction

   assign raw   = {pl_q[31], pl_q[23], pl_q[15], pl_q[7]};
   assign entry = {attr_q, raw};

   always_comb begin
      pl_d    = pl_q;
      attr_d  = attr_q;
      cnt_d   = cnt_q;
      lderr_d = lderr_q;
      undr_d  = undr_q;
      if (LOAD) begin
         if (FLIPX)
            pl_d = {rev8(D[31:24]), rev8(D[23:16]),
                    rev8(D[15:8]), rev8(D[7:0])};
         else
            pl_d = D;
         attr_d = ATTR;
         cnt_d  = 3'd0;
         if (cnt_q != 3'd7) lderr_d = 1'b1;
      end else begin
         pl_d = {pl_q[30:24], 1'b0, pl_q[22:16], 1'b0,
                 pl_q[14:8], 1'b0, pl_q[6:0], 1'b0};
         cnt_d = cnt_q + 3'd1;
         // Running past the last pixel without a new word
         if (cnt_q == 3'd7) undr_d = 1'b1;
      end
   end

   always_comb begin
      dl_d[0] = entry;
      for (int k = 1; k < 8; k++) dl_d[k] = dl_q[k-1];
      out_d = (FINE == 3'd0) ? entry : dl_q[FINE - 3'd1];
   end

   always_ff @(posedge CK or posedge CL) begin
      if (CL) begin
         pl_q    <= '0;
         attr_q  <= '0;
         cnt_q   <= 3'd7;
         lderr_q <= 1'b0;
         undr_q  <= 1'b0;
         out_q   <= '0;
         for (int k = 0; k < 8; k++) dl_q[k] <= '0;
      end else if (PE) begin
         pl_q    <= pl_d;
         attr_q  <= attr_d;
         cnt_q   <= cnt_d;
         lderr_q <= lderr_d;
         undr_q  <= undr_d;
         out_q   <= out_d;
         for (int k = 0; k < 8; k++) dl_q[k] <= dl_d[k];
      end
   end

   assign PIX   = out_q[3:0];
   assign COL   = out_q[EW-1:4];
   assign TRANS = (out_q[3:0] == 4'd0);
   assign CNT   = cnt_q;
   assign LDERR = lderr_q;
   assign UNDR  = undr_q;

endmodule

// File: tb/tb_k051962_tile_shifter.sv
// Directed bench for k051962_tile_shifter: tile order, flip, fine delay,
// PE gating, alignment flags and asynchronous reset.
module tb_k051962_tile_shifter;

   logic        CK, CL, PE, LOAD, FLIPX;
   logic [31:0] D;
   logic [7:0]  ATTR, COL;
   logic [2:0]  FINE, CNT;
   logic [3:0]  PIX;
   logic        TRANS, LDERR, UNDR;

   int errors = 0;
   int checks = 0;

   logic [3:0] seq_a [8];
   logic [3:0] seq_b [8];

   k051962_tile_shifter #(.ATTR_W(8)) dut (
      .CK(CK), .CL(CL), .PE(PE), .LOAD(LOAD), .D(D),
      .FLIPX(FLIPX), .ATTR(ATTR), .FINE(FINE),
      .PIX(PIX), .COL(COL), .TRANS(TRANS), .CNT(CNT),
      .LDERR(LDERR), .UNDR(UNDR)
   );

   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic pe, input logic ld,
                       input logic [31:0] d, input logic fl,
                       input logic [7:0] at, input logic [2:0] fn);
      PE = pe; LOAD = ld; D = d; FLIPX = fl; ATTR = at; FINE = fn;
      @(posedge CK);
      #1;
      PE = 1'b0; LOAD = 1'b0;
   endtask

   task automatic reset_dut();
      CL = 1'b1;
      #3;
      CL = 1'b0;
   endtask

   initial begin
      seq_a = '{4'h8, 4'h8, 4'h8, 4'h8, 4'hB, 4'hB, 4'hB, 4'hB};
      seq_b = '{4'hB, 4'hB, 4'hB, 4'hB, 4'h8, 4'h8, 4'h8, 4'h8};
      CL = 1'b1; PE = 1'b0; LOAD = 1'b0; D = '0;
      FLIPX = 1'b0; ATTR = '0; FINE = '0;
      #12;
      chk("rst_pix", PIX, 0);
      chk("rst_col", COL, 0);
      chk("rst_cnt", CNT, 7);
      chk("rst_trans", TRANS, 1);
      chk("rst_flags", {LDERR, UNDR}, 0);
      CL = 1'b0;

      // Plain order, then flipped order
      step(1, 1, 32'hFF000F0F, 0, 8'h5A, 0);
      chk("a_ld_cnt", CNT, 0);
      chk("a_ld_pix", PIX, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, i == 7, 32'hFF000F0F, 1, 8'h5A, 0);
         chk("a_pix", PIX, seq_a[i]);
         chk("a_col", COL, 8'h5A);
      end
      chk("a_flags", {LDERR, UNDR}, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, i == 7, 32'h0, 0, 8'h00, 0);
         chk("b_pix", PIX, seq_b[i]);
      end
      chk("b_flags", {LDERR, UNDR}, 0);

      // Fine delay of 3
      reset_dut();
      step(1, 1, 32'h80000000, 0, 8'h11, 3);
      for (int i = 1; i <= 8; i++) begin
         step(1, i == 8, 32'h0, 0, 8'h11, 3);
         chk("f_pix", PIX, (i == 4) ? 4'h8 : 4'h0);
         chk("f_trans", TRANS, (i == 4) ? 1'b0 : 1'b1);
      end
      chk("f_flags", {LDERR, UNDR}, 0);

      // PE on every third clock
      reset_dut();
      step(1, 1, 32'hFF000F0F, 0, 8'h5A, 0);
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 2; j++) begin
            step(0, 1, 32'h0, 0, 8'h00, 5);
            chk("g_hold_pix", PIX, (i == 0) ? 4'h0 : seq_a[i-1]);
            chk("g_hold_cnt", CNT, i);
         end
         step(1, i == 7, 32'hFF000F0F, 0, 8'h5A, 0);
         chk("g_pix", PIX, seq_a[i]);
         chk("g_col", COL, 8'h5A);
      end
      chk("g_flags", {LDERR, UNDR}, 0);

      // Misaligned load, then a missing load
      reset_dut();
      step(1, 1, 32'hFF000F0F, 0, 8'h5A, 0);
      for (int i = 0; i < 3; i++) step(1, 0, 32'h0, 0, 8'h00, 0);
      chk("m_cnt3", CNT, 3);
      chk("m_ld0", LDERR, 0);
      step(1, 1, 32'h000000F0, 0, 8'h33, 0);
      chk("m_lderr", LDERR, 1);
      chk("m_cnt0", CNT, 0);
      chk("m_old_pix", PIX, 4'h8);
      for (int i = 0; i < 7; i++) begin
         step(1, 0, 32'h0, 0, 8'h00, 0);
         chk("m_pix", PIX, (i < 4) ? 4'h1 : 4'h0);
      end
      chk("m_cnt7", CNT, 7);
      chk("m_ud0", UNDR, 0);
      step(1, 0, 32'h0, 0, 8'h00, 0);
      chk("m_undr", UNDR, 1);
      chk("m_wrap", CNT, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 32'h0, 0, 8'h00, 0);
         chk("u_pix", PIX, 0);
         chk("u_trans", TRANS, 1);
      end
      chk("u_sticky", {LDERR, UNDR}, 2'b11);

      // Asynchronous reset mid-tile
      step(1, 1, 32'hFF000F0F, 0, 8'h5A, 0);
      step(1, 0, 32'h0, 0, 8'h00, 0);
      step(1, 0, 32'h0, 0, 8'h00, 0);
      chk("c_pre_pix", PIX, 4'h8);
      chk("c_pre_col", COL, 8'h5A);
      #2;
      CL = 1'b1;
      #1;
      chk("c_pix", PIX, 0);
      chk("c_col", COL, 0);
      chk("c_cnt", CNT, 7);
      chk("c_trans", TRANS, 1);
      chk("c_flags", {LDERR, UNDR}, 0);
      CL = 1'b0;
      step(1, 1, 32'hFF000F0F, 0, 8'h5A, 0);
      chk("c_realign", LDERR, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
